// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports (core and debug/loader) and the memory
// bank port of the data-memory arbiter. Signal suffixes are written from the
// arbiter's point of view: _i enters the arbiter, _o leaves it.
interface dmem_arbiter_if;
  // core (MEM stage) port
  logic        core_req_i;
  logic        core_we_i;
  logic [12:0] core_addr_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_wdata_i;
  logic        core_gnt_o;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        core_stall_o;

  // debug / loader port
  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [12:0] dbg_addr_i;
  logic [3:0]  dbg_be_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_gnt_o;
  logic        dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;

  // memory bank port
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [12:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  // arbiter side
  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_be_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_be_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // requester / memory-model side
  modport master (
    output core_req_i, core_we_i, core_addr_i, core_be_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_be_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the core normally wins a conflict, but after
// STARVE_MAX consecutive lost conflicts the debug/loader port is forced a
// grant. Grants are combinational; read data returns exactly one cycle later
// and is steered to whichever port issued the read.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4  // 1..15
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dmem_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rsp_pending_q, rsp_pending_d;
  logic       rsp_owner_q, rsp_owner_d;  // 1 = debug port owns the response

  logic conflict;
  logic dbg_wins;
  logic core_gnt;
  logic dbg_gnt;

  // Arbitration and memory-port steering; reset masks every grant so the bank
  // is idle while rst_ni is low, independent of the clock.
  always_comb begin
    conflict = bus.core_req_i & bus.dbg_req_i;
    dbg_wins = bus.dbg_req_i & (~bus.core_req_i | (starve_cnt_q == STARVE_LIM));
    core_gnt = rst_ni & bus.core_req_i & ~dbg_wins;
    dbg_gnt  = rst_ni & dbg_wins;

    bus.core_gnt_o   = core_gnt;
    bus.dbg_gnt_o    = dbg_gnt;
    bus.core_stall_o = bus.core_req_i & ~core_gnt;

    bus.mem_en_o = core_gnt | dbg_gnt;
    if (dbg_gnt) begin
      bus.mem_addr_o  = bus.dbg_addr_i;
      bus.mem_wdata_o = bus.dbg_wdata_i;
      bus.mem_we_o    = bus.dbg_we_i ? bus.dbg_be_i : 4'b0000;
    end else begin
      // idle cycles still present the core's address/data to the bank
      bus.mem_addr_o  = bus.core_addr_i;
      bus.mem_wdata_o = bus.core_wdata_i;
      bus.mem_we_o    = (core_gnt && bus.core_we_i) ? bus.core_be_i : 4'b0000;
    end
  end

  // Next-state for the starvation counter and the one-deep response tracker.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (dbg_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (conflict && core_gnt && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    rsp_pending_d = (core_gnt & ~bus.core_we_i) | (dbg_gnt & ~bus.dbg_we_i);
    rsp_owner_d   = dbg_gnt;
  end

  // State registers; an asserted reset drops any in-flight read response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q  <= 4'd0;
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= 1'b0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
    end
  end

  // Response steering: only the owning port sees valid data, others read zero.
  always_comb begin
    bus.core_rvalid_o = rsp_pending_q & ~rsp_owner_q;
    bus.dbg_rvalid_o  = rsp_pending_q & rsp_owner_q;
    bus.core_rdata_o  = bus.core_rvalid_o ? bus.mem_rdata_i : 32'h0;
    bus.dbg_rdata_o   = bus.dbg_rvalid_o ? bus.mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. A behavioural single-cycle-latency RAM
// preloaded with 0x1000_0000 | addr sits on the memory port; all expected
// values are hand-derived constants from that preload pattern.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;

  int n_cmp = 0;
  int n_mis = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // memory model: registered read (read-before-write), byte-lane writes
  logic [31:0] mem [0:8191];
  logic [31:0] rd_q = 32'h0;
  assign bus.mem_rdata_i = rd_q;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 32'h1000_0000 | 32'(i);
    end else if (bus.mem_en_o) begin
      rd_q <= mem[bus.mem_addr_o];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we_o[b]) mem[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic set_core(input logic req, input logic we, input logic [12:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
    bus.core_req_i   = req;
    bus.core_we_i    = we;
    bus.core_addr_i  = a;
    bus.core_be_i    = be;
    bus.core_wdata_i = wd;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    bus.dbg_req_i   = req;
    bus.dbg_we_i    = we;
    bus.dbg_addr_i  = a;
    bus.dbg_be_i    = be;
    bus.dbg_wdata_i = wd;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_core(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);

    // reset with both ports requesting: nothing may be granted
    cyc(); mem_init = 1'b0;
    set_core(1'b1, 1'b0, 13'h001, 4'hF, 32'h0);
    set_dbg(1'b1, 1'b1, 13'h002, 4'hF, 32'h0);
    look();
    check_eq("rst_core_gnt", bus.core_gnt_o, 32'd0);
    check_eq("rst_dbg_gnt", bus.dbg_gnt_o, 32'd0);
    check_eq("rst_mem_en", bus.mem_en_o, 32'd0);
    check_eq("rst_mem_we", bus.mem_we_o, 32'd0);
    check_eq("rst_core_rvalid", bus.core_rvalid_o, 32'd0);
    check_eq("rst_dbg_rvalid", bus.dbg_rvalid_o, 32'd0);
    check_eq("rst_core_rdata", bus.core_rdata_o, 32'd0);

    // release reset, idle cycle
    cyc(); rst_n = 1'b1;
    set_core(1'b0, 1'b0, 13'h000, 4'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 13'h000, 4'h0, 32'h0);
    look();
    check_eq("idle_mem_en", bus.mem_en_o, 32'd0);

    // core read of 0x005
    cyc(); set_core(1'b1, 1'b0, 13'h005, 4'hF, 32'h0); look();
    check_eq("rd5_core_gnt", bus.core_gnt_o, 32'd1);
    check_eq("rd5_mem_en", bus.mem_en_o, 32'd1);
    check_eq("rd5_mem_addr", bus.mem_addr_o, 32'h005);
    check_eq("rd5_mem_we", bus.mem_we_o, 32'd0);
    check_eq("rd5_stall", bus.core_stall_o, 32'd0);
    cyc(); set_core(1'b0, 1'b0, 13'h123, 4'hF, 32'h55AA_1234); look();
    check_eq("rd5_core_rvalid", bus.core_rvalid_o, 32'd1);
    check_eq("rd5_core_rdata", bus.core_rdata_o, 32'h1000_0005);
    check_eq("rd5_dbg_rvalid", bus.dbg_rvalid_o, 32'd0);
    check_eq("nogrant_mem_addr", bus.mem_addr_o, 32'h123);
    check_eq("nogrant_mem_wdata", bus.mem_wdata_o, 32'h55AA_1234);
    check_eq("nogrant_mem_en", bus.mem_en_o, 32'd0);

    // debug write 0x010, be=0011
    cyc(); set_dbg(1'b1, 1'b1, 13'h010, 4'b0011, 32'hAABB_CCDD); look();
    check_eq("dwr_dbg_gnt", bus.dbg_gnt_o, 32'd1);
    check_eq("dwr_core_gnt", bus.core_gnt_o, 32'd0);
    check_eq("dwr_mem_we", bus.mem_we_o, 32'b0011);
    check_eq("dwr_mem_addr", bus.mem_addr_o, 32'h010);
    check_eq("dwr_mem_wdata", bus.mem_wdata_o, 32'hAABB_CCDD);
    check_eq("dwr_prev_rdata_zero", bus.core_rdata_o, 32'd0);
    cyc(); set_dbg(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    set_core(1'b1, 1'b0, 13'h010, 4'hF, 32'h0); look();
    check_eq("dwr_core_rvalid", bus.core_rvalid_o, 32'd0);
    check_eq("dwr_dbg_rvalid", bus.dbg_rvalid_o, 32'd0);
    cyc(); set_core(1'b0, 1'b0, 13'h0, 4'h0, 32'h0); look();
    check_eq("dwr_readback", bus.core_rdata_o, 32'h1000_CCDD);

    // continuous conflict: core wins 4 times, debug forced on the 5th
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (c == 0) begin
        set_core(1'b1, 1'b0, 13'h020, 4'hF, 32'h0);
        set_dbg(1'b1, 1'b0, 13'h030, 4'hF, 32'h0);
      end
      look();
      check_eq($sformatf("starve_c%0d_core_gnt", c), bus.core_gnt_o, (c != 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("starve_c%0d_dbg_gnt", c), bus.dbg_gnt_o, (c == 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("starve_c%0d_stall", c), bus.core_stall_o, (c == 4) ? 32'd1 : 32'd0);
      if (c == 1) check_eq("starve_c1_core_rdata", bus.core_rdata_o, 32'h1000_0020);
      if (c == 5) begin
        check_eq("starve_c5_dbg_rvalid", bus.dbg_rvalid_o, 32'd1);
        check_eq("starve_c5_dbg_rdata", bus.dbg_rdata_o, 32'h1000_0030);
        check_eq("starve_c5_core_rvalid", bus.core_rvalid_o, 32'd0);
      end
    end

    // debug read n, core read n+1; response and grant overlap
    cyc(); set_core(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    set_dbg(1'b1, 1'b0, 13'h040, 4'hF, 32'h0); look();
    check_eq("ord_n_dbg_gnt", bus.dbg_gnt_o, 32'd1);
    check_eq("ord_n_core_rdata", bus.core_rdata_o, 32'h1000_0020);
    cyc(); set_dbg(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    set_core(1'b1, 1'b0, 13'h041, 4'hF, 32'h0); look();
    check_eq("ord_n1_core_gnt", bus.core_gnt_o, 32'd1);
    check_eq("ord_n1_dbg_rvalid", bus.dbg_rvalid_o, 32'd1);
    check_eq("ord_n1_dbg_rdata", bus.dbg_rdata_o, 32'h1000_0040);
    check_eq("ord_n1_core_rvalid", bus.core_rvalid_o, 32'd0);
    check_eq("ord_n1_core_rdata", bus.core_rdata_o, 32'd0);
    cyc(); set_core(1'b0, 1'b0, 13'h0, 4'h0, 32'h0); look();
    check_eq("ord_n2_core_rvalid", bus.core_rvalid_o, 32'd1);
    check_eq("ord_n2_core_rdata", bus.core_rdata_o, 32'h1000_0041);
    check_eq("ord_n2_dbg_rvalid", bus.dbg_rvalid_o, 32'd0);
    check_eq("ord_n2_dbg_rdata", bus.dbg_rdata_o, 32'd0);

    // read then write same address: read returns pre-write data
    cyc(); set_core(1'b1, 1'b0, 13'h050, 4'hF, 32'h0); look();
    cyc(); set_core(1'b1, 1'b1, 13'h050, 4'hF, 32'hDEAD_BEEF); look();
    check_eq("rw_mem_we", bus.mem_we_o, 32'hF);
    check_eq("rw_pre_write_rdata", bus.core_rdata_o, 32'h1000_0050);
    cyc(); set_core(1'b1, 1'b0, 13'h050, 4'hF, 32'h0); look();
    check_eq("rw_write_no_rvalid", bus.core_rvalid_o, 32'd0);
    cyc(); set_core(1'b0, 1'b0, 13'h0, 4'h0, 32'h0); look();
    check_eq("rw_post_write_rdata", bus.core_rdata_o, 32'hDEAD_BEEF);

    // core write with be=0: granted, no byte written
    cyc(); set_core(1'b1, 1'b1, 13'h060, 4'h0, 32'hFFFF_FFFF); look();
    check_eq("be0_core_gnt", bus.core_gnt_o, 32'd1);
    check_eq("be0_mem_en", bus.mem_en_o, 32'd1);
    check_eq("be0_mem_we", bus.mem_we_o, 32'd0);
    cyc(); set_core(1'b1, 1'b0, 13'h060, 4'hF, 32'h0); look();
    check_eq("be0_no_rvalid", bus.core_rvalid_o, 32'd0);
    cyc(); set_core(1'b0, 1'b0, 13'h0, 4'h0, 32'h0); look();
    check_eq("be0_unchanged", bus.core_rdata_o, 32'h1000_0060);

    // build up starve count, then reset in the middle of a core read
    cyc(); set_core(1'b1, 1'b0, 13'h070, 4'hF, 32'h0);
    set_dbg(1'b1, 1'b0, 13'h071, 4'hF, 32'h0); look();
    check_eq("pre_rst_c0_core_gnt", bus.core_gnt_o, 32'd1);
    cyc(); look();
    check_eq("pre_rst_c1_core_gnt", bus.core_gnt_o, 32'd1);
    cyc(); set_dbg(1'b0, 1'b0, 13'h0, 4'h0, 32'h0); look();
    check_eq("mid_rd_core_gnt", bus.core_gnt_o, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_core_gnt", bus.core_gnt_o, 32'd0);
    check_eq("async_rst_mem_en", bus.mem_en_o, 32'd0);
    cyc(); look();
    check_eq("in_rst_core_rvalid", bus.core_rvalid_o, 32'd0);
    cyc(); rst_n = 1'b1;
    set_core(1'b1, 1'b0, 13'h070, 4'hF, 32'h0);
    set_dbg(1'b1, 1'b0, 13'h071, 4'hF, 32'h0);
    look();
    for (int c = 0; c < 5; c++) begin
      if (c != 0) begin
        cyc(); look();
      end
      if (c == 0) check_eq("post_rst_core_rvalid", bus.core_rvalid_o, 32'd0);
      check_eq($sformatf("post_rst_c%0d_core_gnt", c), bus.core_gnt_o, (c != 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("post_rst_c%0d_dbg_gnt", c), bus.dbg_gnt_o, (c == 4) ? 32'd1 : 32'd0);
    end

    cyc();
    set_core(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
